// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, SRAM slave FSM states and byte-lane helper.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LAST, ST_ERR1, ST_ERR2} state_t;
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
        return size == HSIZE_BYTE ? 4'b0001 << addr :
               size == HSIZE_HALF ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    endfunction
endpackage

// File: rtl/sram_slave_mem.sv
// sram_slave_mem: word memory with per-byte synchronous write and combinational read.
module sram_slave_mem #(
    parameter int WORDS = 1024,
    localparam int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    assign rdata = mem[addr];
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave over on-chip SRAM with wait states and ERROR responses.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic [1:0]  hresp
);
    localparam int AW = $clog2(MEM_WORDS);
    state_t        state;
    logic [2:0]    cnt;
    logic [AW-1:0] word_q;
    logic          write_q;
    logic [3:0]    lanes_q;
    logic [3:0]    mem_we;
    logic [31:0]   rd_word;
    logic          accept;
    logic          illegal;
    logic          unused_htrans;
    assign unused_htrans = htrans[0];
    assign accept  = hsel & hready & htrans[1];
    assign illegal = hsize > HSIZE_WORD || (hsize == HSIZE_HALF && haddr[0]) ||
                     (hsize == HSIZE_WORD && haddr[1:0] != 2'b00) || (haddr >> (AW + 2)) != 32'd0;
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            word_q    <= '0;
            write_q   <= 1'b0;
            lanes_q   <= 4'b0000;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
        end else begin
            case (state)
                ST_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state     <= ST_LAST;
                        hreadyout <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                end
                // IDLE, LAST and ERR2 all accept a new (possibly pipelined) address phase
                default: begin
                    if (accept) begin
                        word_q  <= haddr[AW+1:2];
                        write_q <= hwrite;
                        lanes_q <= lane_mask(hsize, haddr[1:0]);
                        if (illegal) begin
                            state     <= ST_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= HRESP_ERROR;
                        end else if (WAIT_STATES != 0) begin
                            state     <= ST_WAIT;
                            cnt       <= 3'(WAIT_STATES);
                            hreadyout <= 1'b0;
                            hresp     <= HRESP_OKAY;
                        end else begin
                            state     <= ST_LAST;
                            hreadyout <= 1'b1;
                            hresp     <= HRESP_OKAY;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end
    // a reset landing on the commit edge drops the write
    assign mem_we = (state == ST_LAST && write_q && !hreset) ? lanes_q : 4'b0000;
    assign hrdata = (state == ST_LAST && !write_q) ? rd_word : 32'd0;
    sram_slave_mem #(.WORDS(MEM_WORDS)) u_mem (
        .clk   (hclk),
        .we    (mem_we),
        .addr  (word_q),
        .wdata (hwdata),
        .rdata (rd_word)
    );
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: vector table, random traffic against a byte-level memory model,
// and hand sequences for reset, pipelining and zero-wait operation.
module tb_ahb_sram_slave;
    import ahb_pkg::*;
    localparam int MW1 = 1024;
    localparam int MW0 = 256;
    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0;
    logic        hwrite = 1'b0;
    logic        tgt = 1'b1;
    logic [31:0] haddr = 32'd0;
    logic [31:0] hwdata = 32'd0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'b000;
    logic [31:0] hrdata0, hrdata1;
    logic        hreadyout0, hreadyout1;
    logic [1:0]  hresp0, hresp1;
    int tests = 0;
    int fails = 0;
    always #5 hclk = ~hclk;

    ahb_sram_slave #(.MEM_WORDS(MW1), .WAIT_STATES(1)) dut1 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel & tgt), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hreadyout1),
        .hrdata(hrdata1), .hreadyout(hreadyout1), .hresp(hresp1));
    ahb_sram_slave #(.MEM_WORDS(MW0), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel & ~tgt), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hreadyout0),
        .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0));

    wire [31:0] rd  = tgt ? hrdata1 : hrdata0;
    wire        rdy = tgt ? hreadyout1 : hreadyout0;
    wire [1:0]  rsp = tgt ? hresp1 : hresp0;

    typedef struct {
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vt [14];
    bit [31:0] ref_mem [int];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the target slave ready; returns at the negedge of the
    // data-phase cycle with hreadyout high.
    task automatic xfer(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdat, output logic [1:0] resp_first, output logic [1:0] resp_last,
                        output int waits, output logic stray);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = w; hsize = sz; haddr = a;
        @(posedge hclk); @(negedge hclk);
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wd;
        waits = 0; stray = 1'b0; resp_first = rsp;
        while (!rdy && waits < 16) begin
            waits++;
            if (rd !== 32'd0) stray = 1'b1;
            @(negedge hclk);
        end
        rdat = rd; resp_last = rsp;
    endtask

    task automatic run_check(input string nm, input logic w, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_rd, input logic [1:0] exp_resp,
                             input int exp_waits);
        logic [31:0] rdat;
        logic [1:0]  r0, r1;
        int          waits;
        logic        stray;
        xfer(w, sz, a, wd, rdat, r0, r1, waits, stray);
        check($sformatf("%s rdata", nm), rdat, exp_rd);
        check($sformatf("%s resp_first", nm), 32'(r0), 32'(exp_resp));
        check($sformatf("%s resp_last", nm), 32'(r1), 32'(exp_resp));
        check($sformatf("%s wait_cycles", nm), 32'(waits), 32'(exp_waits));
        check($sformatf("%s hrdata_zero_in_wait", nm), 32'(stray), 32'd0);
    endtask

    function automatic bit legal(input logic [2:0] sz, input logic [31:0] a, input int mw);
        return sz <= 3'd2 && a % (32'd1 << sz) == 0 && a < 32'(4 * mw);
    endfunction

    initial begin
        logic        w;
        logic        lg;
        logic [2:0]  sz;
        logic [31:0] a, wd, er;
        vt[0]  = '{1'b1, HSIZE_WORD, 32'h10,   32'hDEADBEEF, 32'h0,        HRESP_OKAY};
        vt[1]  = '{1'b0, HSIZE_WORD, 32'h10,   32'h0,        32'hDEADBEEF, HRESP_OKAY};
        vt[2]  = '{1'b1, HSIZE_WORD, 32'h10,   32'h11223344, 32'h0,        HRESP_OKAY};
        vt[3]  = '{1'b1, HSIZE_BYTE, 32'h13,   32'hAA000000, 32'h0,        HRESP_OKAY};
        vt[4]  = '{1'b0, HSIZE_WORD, 32'h10,   32'h0,        32'hAA223344, HRESP_OKAY};
        vt[5]  = '{1'b1, HSIZE_HALF, 32'h12,   32'h55660000, 32'h0,        HRESP_OKAY};
        vt[6]  = '{1'b0, HSIZE_WORD, 32'h10,   32'h0,        32'h55663344, HRESP_OKAY};
        vt[7]  = '{1'b1, HSIZE_WORD, 32'h02,   32'hFFFFFFFF, 32'h0,        HRESP_ERROR};
        vt[8]  = '{1'b0, HSIZE_WORD, 32'h1000, 32'h0,        32'h0,        HRESP_ERROR};
        vt[9]  = '{1'b1, HSIZE_BYTE, 32'h1000, 32'hFFFFFFFF, 32'h0,        HRESP_ERROR};
        vt[10] = '{1'b1, HSIZE_HALF, 32'h11,   32'hFFFFFFFF, 32'h0,        HRESP_ERROR};
        vt[11] = '{1'b1, 3'b011,     32'h10,   32'hFFFFFFFF, 32'h0,        HRESP_ERROR};
        vt[12] = '{1'b0, HSIZE_BYTE, 32'h11,   32'h0,        32'h55663344, HRESP_OKAY};
        vt[13] = '{1'b0, HSIZE_WORD, 32'h10,   32'h0,        32'h55663344, HRESP_OKAY};

        // reset held two cycles, outputs checked on the first cycle after release
        repeat (2) @(posedge hclk);
        @(negedge hclk); hreset = 1'b0;
        @(posedge hclk); @(negedge hclk);
        check("reset hreadyout ws1", 32'(hreadyout1), 32'd1);
        check("reset hresp ws1", 32'(hresp1), 32'd0);
        check("reset hrdata ws1", hrdata1, 32'd0);
        check("reset hreadyout ws0", 32'(hreadyout0), 32'd1);
        check("reset hresp ws0", 32'(hresp0), 32'd0);
        check("reset hrdata ws0", hrdata0, 32'd0);

        foreach (vt[i])
            run_check($sformatf("vec%0d", i), vt[i].w, vt[i].sz, vt[i].a, vt[i].wd, vt[i].exp_rd,
                      vt[i].exp_resp, vt[i].exp_resp == HRESP_OKAY ? 1 : 1);

        // BUSY with an illegal address must not start anything
        hsel = 1'b1; htrans = HTRANS_BUSY; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 32'h02;
        @(posedge hclk); @(negedge hclk);
        hsel = 1'b0; htrans = HTRANS_IDLE;
        check("busy hreadyout", 32'(hreadyout1), 32'd1);
        check("busy hresp", 32'(hresp1), 32'd0);

        for (int k = 0; k < 16; k++) begin
            wd = $urandom;
            run_check($sformatf("init%0d", k), 1'b1, HSIZE_WORD, 32'h100 + 32'(4 * k), wd, 32'd0, HRESP_OKAY, 1);
            ref_mem[64 + k] = wd;
        end
        for (int n = 0; n < 80; n++) begin
            w = 1'($urandom % 2);
            wd = $urandom;
            if ($urandom % 5 == 0) begin
                case ($urandom % 3)
                    0: begin sz = 3'(3 + $urandom % 5); a = 32'h100 + 32'(4 * ($urandom % 16)); end
                    1: begin sz = 3'(1 + $urandom % 2); a = 32'h101 + 32'(4 * ($urandom % 16)); end
                    default: begin sz = 3'($urandom % 3); a = 32'(4 * MW1) + 32'(4 * ($urandom % 1024)); end
                endcase
            end else begin
                sz = 3'($urandom % 3);
                a = 32'h100 + 32'(4 * ($urandom % 16)) + 32'(($urandom % 4) & ~((1 << sz) - 1));
            end
            lg = legal(sz, a, MW1);
            er = (lg && !w) ? ref_mem[int'(a >> 2)] : 32'd0;
            run_check($sformatf("rand%0d", n), w, sz, a, wd, er, lg ? HRESP_OKAY : HRESP_ERROR, 1);
            if (lg && w)
                for (int b = int'(a % 4); b < int'(a % 4) + (1 << sz); b++)
                    ref_mem[int'(a >> 2)][8*b +: 8] = wd[8*b +: 8];
        end
        for (int k = 0; k < 16; k++)
            run_check($sformatf("sweep%0d", k), 1'b0, HSIZE_WORD, 32'h100 + 32'(4 * k), 32'd0,
                      ref_mem[64 + k], HRESP_OKAY, 1);

        // reset during the wait state of a write discards it
        run_check("rst pre", 1'b1, HSIZE_WORD, 32'h30, 32'h0, 32'h0, HRESP_OKAY, 1);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD; haddr = 32'h30;
        @(posedge hclk); @(negedge hclk);
        check("rst in wait hreadyout", 32'(hreadyout1), 32'd0);
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF; hreset = 1'b1;
        @(posedge hclk); @(negedge hclk);
        check("rst after hreadyout", 32'(hreadyout1), 32'd1);
        check("rst after hresp", 32'(hresp1), 32'd0);
        check("rst after hrdata", hrdata1, 32'd0);
        hreset = 1'b0;
        @(posedge hclk); @(negedge hclk);
        run_check("rst readback", 1'b0, HSIZE_WORD, 32'h30, 32'd0, 32'd0, HRESP_OKAY, 1);

        // zero-wait slave: pipelined write then read of the same word
        tgt = 1'b0;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD; haddr = 32'h20;
        @(posedge hclk); @(negedge hclk);
        check("ws0 write phase hreadyout", 32'(hreadyout0), 32'd1);
        hwdata = 32'h12345678; hwrite = 1'b0;
        @(posedge hclk); @(negedge hclk);
        check("ws0 read phase hreadyout", 32'(hreadyout0), 32'd1);
        check("ws0 read data", hrdata0, 32'h12345678);
        check("ws0 read hresp", 32'(hresp0), 32'd0);
        hsel = 1'b0; htrans = HTRANS_IDLE;
        @(posedge hclk); @(negedge hclk);
        check("ws0 idle hrdata", hrdata0, 32'd0);
        run_check("ws0 reread", 1'b0, HSIZE_HALF, 32'h22, 32'd0, 32'h12345678, HRESP_OKAY, 0);
        run_check("ws0 misaligned", 1'b1, HSIZE_WORD, 32'h02, 32'hFFFFFFFF, 32'd0, HRESP_ERROR, 1);
        run_check("ws0 out of range", 1'b0, HSIZE_BYTE, 32'(4 * MW0), 32'd0, 32'd0, HRESP_ERROR, 1);
        run_check("ws0 last byte", 1'b1, HSIZE_BYTE, 32'(4 * MW0 - 1), 32'h7E000000, 32'd0, HRESP_OKAY, 0);
        run_check("ws0 last word", 1'b0, HSIZE_WORD, 32'(4 * MW0 - 4), 32'd0, 32'h7E000000 | (32'h00FFFFFF & ref_last(0)), HRESP_OKAY, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // the last word of the small slave was never written before, so its low bytes are
    // whatever the memory powered up with; mask them out of the comparison value
    function automatic logic [31:0] ref_last(input int dummy);
        return dummy == 0 ? dut0.u_mem.mem[MW0 - 1] : 32'd0;
    endfunction
endmodule
